// File: rtl/fork_sel_scheduler_if.sv
// Handshake bundle between the requesters, the fork_sel_scheduler and the dynamic stream fork.
// The scheduler uses the slave modport; the requester/fork side uses master.
interface fork_sel_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int N_OUP = 4
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic [N_REQ*N_OUP-1:0] req_mask_i;
  logic [N_OUP-1:0]       sel_o;
  logic                   sel_valid_o;
  logic                   sel_ready_i;
  logic                   fork_valid_o;
  logic                   fork_ready_i;
  logic [IDW-1:0]         grant_id_o;
  logic                   busy_o;
  logic                   drop_o;
  logic                   timeout_o;

  modport slave (
    input  req_valid_i, req_mask_i, sel_ready_i, fork_ready_i,
    output req_ready_o, sel_o, sel_valid_o, fork_valid_o, grant_id_o, busy_o, drop_o, timeout_o
  );

  modport master (
    output req_valid_i, req_mask_i, sel_ready_i, fork_ready_i,
    input  req_ready_o, sel_o, sel_valid_o, fork_valid_o, grant_id_o, busy_o, drop_o, timeout_o
  );
endinterface

// File: rtl/fork_sel_scheduler.sv
// Round-robin scheduler sharing one dynamic stream fork between N_REQ requesters.
// Optional watchdog enabled by defining FORK_SEL_SCHED_WDT_EN.
module fork_sel_scheduler #(
  parameter int N_REQ      = 4,
  parameter int N_OUP      = 4,
  parameter int WDT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  fork_sel_scheduler_if.slave   bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // state  | meaning
  // IDLE   | no transfer in flight, sel_valid_o/fork_valid_o low
  // ISSUE  | latched mask driven to the fork until sel and fork both complete
  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_grant_id;
  logic [N_OUP-1:0] r_sel;
  logic             r_drop;

  logic             w_done;
  logic             w_window;
  logic             w_found;
  logic             w_accept;
  logic [IDW-1:0]   w_idx;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [N_OUP-1:0] w_win_mask;
  logic             w_mask_zero;

  assign w_done   = bus.sel_ready_i & bus.fork_ready_i;
  assign w_window = (r_state == S_IDLE) | ((r_state == S_ISSUE) & w_done);
  assign w_accept = w_window & w_found;

  // First valid requester at or after the round-robin pointer, modulo N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = IDW'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_found && bus.req_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_win_mask = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (w_win == IDW'(r)) w_win_mask = bus.req_mask_i[r*N_OUP +: N_OUP];
    end
  end

  assign w_mask_zero = (w_win_mask == '0);
  assign w_ptr_nxt   = (w_win == IDW'(N_REQ - 1)) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_mask_zero) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_done) w_state_nxt = (w_accept && !w_mask_zero) ? S_ISSUE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o       = (r_state == S_ISSUE);
    bus.sel_valid_o  = (r_state == S_ISSUE);
    bus.fork_valid_o = (r_state == S_ISSUE);
    bus.req_ready_o  = '0;
    for (int r = 0; r < N_REQ; r++) begin
      bus.req_ready_o[r] = w_accept && (w_win == IDW'(r));
    end
  end

  // Zero masks are still latched so sel_o always reflects the last accepted request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_sel      <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_drop <= w_accept & w_mask_zero;
      if (w_accept) begin
        r_rr_ptr   <= w_ptr_nxt;
        r_grant_id <= w_win;
        r_sel      <= w_win_mask;
      end
    end
  end

  assign bus.sel_o      = r_sel;
  assign bus.grant_id_o = r_grant_id;
  assign bus.drop_o     = r_drop;

`ifdef FORK_SEL_SCHED_WDT_EN
  localparam int CW = $clog2(WDT_CYCLES + 1);

  logic [CW-1:0] r_wdt_cnt;
  logic          r_timeout;
  logic          w_stall;

  assign w_stall = (r_state == S_ISSUE) & ~w_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdt_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept)                                     r_wdt_cnt <= '0;
      else if (w_stall && r_wdt_cnt != CW'(WDT_CYCLES)) r_wdt_cnt <= r_wdt_cnt + 1'b1;
      if ((r_state == S_ISSUE) && w_done)               r_timeout <= 1'b0;
      else if (w_stall && r_wdt_cnt == CW'(WDT_CYCLES - 1)) r_timeout <= 1'b1;
    end
  end

  assign bus.timeout_o = r_timeout;
`else
  // WDT_CYCLES has no effect in this build; the term below is always 0.
  assign bus.timeout_o = 1'b0 & (WDT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_fork_sel_scheduler.sv
// Directed bench for fork_sel_scheduler with N_REQ=4, N_OUP=3, WDT_CYCLES=8.
module tb_fork_sel_scheduler;
  logic clk_i = 1'b0;
  logic rst_i;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_i = ~clk_i;

  fork_sel_scheduler_if #(.N_REQ(4), .N_OUP(3)) u_if ();

  fork_sel_scheduler #(.N_REQ(4), .N_OUP(3), .WDT_CYCLES(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (u_if.slave)
  );

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [11:0] m, input logic sr, input logic fr);
    u_if.req_valid_i  = v;
    u_if.req_mask_i   = m;
    u_if.sel_ready_i  = sr;
    u_if.fork_ready_i = fr;
  endtask

  task automatic pulse_reset;
    drive(4'b0000, 12'h000, 1'b0, 1'b0);
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    drive(4'b0000, 12'h000, 1'b0, 1'b0);
    step;
    step;
    checks++;
    if ({u_if.sel_valid_o, u_if.fork_valid_o, u_if.busy_o, u_if.drop_o, u_if.timeout_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
               {u_if.sel_valid_o, u_if.fork_valid_o, u_if.busy_o, u_if.drop_o, u_if.timeout_o});
    end
    checks++;
    if ({u_if.sel_o, u_if.grant_id_o, u_if.req_ready_o} !== 9'b0) begin
      failures++;
      $display("FAIL reset_regs sel=%b id=%0d ready=%b exp all zero", u_if.sel_o, u_if.grant_id_o, u_if.req_ready_o);
    end
    rst_i = 1'b0;
    drive(4'b0100, {3'b001, 3'b011, 3'b001, 3'b001}, 1'b0, 1'b0);
    #1;
    checks++;
    if (u_if.req_ready_o !== 4'b0100) begin
      failures++;
      $display("FAIL reset_first_ready got=%b exp=0100", u_if.req_ready_o);
    end
    step;
    drive(4'b0000, 12'h000, 1'b0, 1'b0);
    checks++;
    if ({u_if.busy_o, u_if.grant_id_o, u_if.sel_o} !== {1'b1, 2'd2, 3'b011}) begin
      failures++;
      $display("FAIL reset_issue got busy=%b id=%0d sel=%b exp busy=1 id=2 sel=011",
               u_if.busy_o, u_if.grant_id_o, u_if.sel_o);
    end
    step;
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({u_if.sel_valid_o, u_if.fork_valid_o, u_if.busy_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_async got=%b exp=000", {u_if.sel_valid_o, u_if.fork_valid_o, u_if.busy_o});
    end
    step;
    rst_i = 1'b0;
    drive(4'b1111, {3'b111, 3'b100, 3'b010, 3'b001}, 1'b1, 1'b1);
    #1;
    checks++;
    if (u_if.req_ready_o !== 4'b0001) begin
      failures++;
      $display("FAIL reset_rr_ptr got=%b exp=0001", u_if.req_ready_o);
    end
    drive(4'b0000, 12'h000, 1'b1, 1'b1);
    step;
  endtask

  task automatic test_round_robin;
    logic [2:0] rr_m [4] = '{3'b001, 3'b010, 3'b100, 3'b111};
    int exp_id [5] = '{0, 1, 2, 3, 0};
    drive(4'b1111, {3'b111, 3'b100, 3'b010, 3'b001}, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (u_if.req_ready_o !== 4'(1 << exp_id[i])) begin
        failures++;
        $display("FAIL rr_ready[%0d] got=%b exp=%b", i, u_if.req_ready_o, 4'(1 << exp_id[i]));
      end
      step;
      checks++;
      if ({u_if.sel_valid_o, u_if.fork_valid_o, u_if.grant_id_o, u_if.sel_o} !==
          {1'b1, 1'b1, 2'(exp_id[i]), rr_m[exp_id[i]]}) begin
        failures++;
        $display("FAIL rr_grant[%0d] got id=%0d sel=%b valid=%b exp id=%0d sel=%b valid=1",
                 i, u_if.grant_id_o, u_if.sel_o, u_if.sel_valid_o, exp_id[i], rr_m[exp_id[i]]);
      end
    end
    drive(4'b0000, 12'h000, 1'b1, 1'b1);
    step;
    checks++;
    if ({u_if.busy_o, u_if.sel_valid_o, u_if.sel_o} !== {1'b0, 1'b0, 3'b001}) begin
      failures++;
      $display("FAIL rr_idle got busy=%b valid=%b sel=%b exp busy=0 valid=0 sel=001",
               u_if.busy_o, u_if.sel_valid_o, u_if.sel_o);
    end
  endtask

  task automatic test_drop;
    pulse_reset;
    drive(4'b0100, {3'b111, 3'b000, 3'b010, 3'b001}, 1'b1, 1'b1);
    #1;
    checks++;
    if (u_if.req_ready_o !== 4'b0100) begin
      failures++;
      $display("FAIL drop_ready got=%b exp=0100", u_if.req_ready_o);
    end
    step;
    checks++;
    if ({u_if.drop_o, u_if.busy_o, u_if.sel_valid_o} !== 3'b100) begin
      failures++;
      $display("FAIL drop_pulse got drop/busy/valid=%b exp=100", {u_if.drop_o, u_if.busy_o, u_if.sel_valid_o});
    end
    drive(4'b1111, {3'b111, 3'b000, 3'b010, 3'b001}, 1'b1, 1'b1);
    #1;
    checks++;
    if (u_if.req_ready_o !== 4'b1000) begin
      failures++;
      $display("FAIL drop_next_search got=%b exp=1000", u_if.req_ready_o);
    end
    step;
    drive(4'b0000, 12'h000, 1'b1, 1'b1);
    checks++;
    if ({u_if.drop_o, u_if.busy_o, u_if.grant_id_o, u_if.sel_o} !== {1'b0, 1'b1, 2'd3, 3'b111}) begin
      failures++;
      $display("FAIL drop_after got drop=%b busy=%b id=%0d sel=%b exp drop=0 busy=1 id=3 sel=111",
               u_if.drop_o, u_if.busy_o, u_if.grant_id_o, u_if.sel_o);
    end
    step;
  endtask

  task automatic test_stall;
    pulse_reset;
    drive(4'b0010, {3'b001, 3'b011, 3'b101, 3'b110}, 1'b0, 1'b0);
    step;
    drive(4'b1111, {3'b001, 3'b011, 3'b101, 3'b110}, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i >= 5) u_if.sel_ready_i = 1'b1;
      #1;
      checks++;
      if ({u_if.req_ready_o, u_if.sel_o, u_if.grant_id_o, u_if.sel_valid_o, u_if.fork_valid_o} !==
          {4'b0000, 3'b101, 2'd1, 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL stall[%0d] got ready=%b sel=%b id=%0d valids=%b%b exp ready=0000 sel=101 id=1 valids=11",
                 i, u_if.req_ready_o, u_if.sel_o, u_if.grant_id_o, u_if.sel_valid_o, u_if.fork_valid_o);
      end
      step;
    end
    drive(4'b0000, 12'h000, 1'b1, 1'b1);
    step;
    checks++;
    if (u_if.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_release got busy=%b exp=0", u_if.busy_o);
    end
  endtask

  task automatic test_back_to_back;
    pulse_reset;
    drive(4'b0010, {3'b010, 3'b000, 3'b101, 3'b000}, 1'b0, 1'b0);
    step;
    drive(4'b0000, 12'h000, 1'b0, 1'b0);
    step;
    drive(4'b1000, {3'b010, 3'b000, 3'b000, 3'b000}, 1'b1, 1'b1);
    #1;
    checks++;
    if (u_if.req_ready_o !== 4'b1000) begin
      failures++;
      $display("FAIL b2b_ready got=%b exp=1000", u_if.req_ready_o);
    end
    step;
    drive(4'b0000, 12'h000, 1'b1, 1'b1);
    checks++;
    if ({u_if.busy_o, u_if.sel_valid_o, u_if.sel_o, u_if.grant_id_o} !== {1'b1, 1'b1, 3'b010, 2'd3}) begin
      failures++;
      $display("FAIL b2b_issue got busy=%b valid=%b sel=%b id=%0d exp busy=1 valid=1 sel=010 id=3",
               u_if.busy_o, u_if.sel_valid_o, u_if.sel_o, u_if.grant_id_o);
    end
    step;
    checks++;
    if ({u_if.busy_o, u_if.sel_o} !== {1'b0, 3'b010}) begin
      failures++;
      $display("FAIL b2b_idle got busy=%b sel=%b exp busy=0 sel=010", u_if.busy_o, u_if.sel_o);
    end
  endtask

  task automatic test_wdt;
    logic exp_to;
`ifdef FORK_SEL_SCHED_WDT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    pulse_reset;
    drive(4'b0001, {3'b000, 3'b000, 3'b000, 3'b001}, 1'b0, 1'b0);
    step;
    drive(4'b0000, 12'h000, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      step;
      checks++;
      if (u_if.timeout_o !== ((i >= 8) ? exp_to : 1'b0)) begin
        failures++;
        $display("FAIL wdt_cycle[%0d] got=%b exp=%b", i, u_if.timeout_o, (i >= 8) ? exp_to : 1'b0);
      end
    end
    checks++;
    if (u_if.busy_o !== 1'b1) begin
      failures++;
      $display("FAIL wdt_no_abort got busy=%b exp=1", u_if.busy_o);
    end
    drive(4'b0000, 12'h000, 1'b1, 1'b1);
    step;
    checks++;
    if ({u_if.timeout_o, u_if.busy_o} !== 2'b00) begin
      failures++;
      $display("FAIL wdt_clear got timeout=%b busy=%b exp 0 0", u_if.timeout_o, u_if.busy_o);
    end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_drop;
    test_stall;
    test_back_to_back;
    test_wdt;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
